// File: rtl/mem_wb_stage_ctrl_pkg.sv
// Shared types and constants for the MEM/WB stage controller.
package mem_wb_stage_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB       = 2'd2
  } state_t;

  localparam int CNT_W = 16;
endpackage

// File: rtl/mem_wb_stage_ctrl_if.sv
// Data-memory request/ack bus between the stage controller and the memory.
interface mem_wb_stage_ctrl_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int DMEM_ADDR_WIDTH = 8
);
  logic                       dmem_req;
  logic                       dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]      dmem_wdata;
  logic                       dmem_ack;
  logic [DATA_WIDTH-1:0]      dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_wb_stage_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module mem_wb_stage_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end
endmodule

// File: rtl/mem_wb_stage_ctrl.sv
// Consumes the ID/EX bundle: issues dmem loads/stores, performs load writeback,
// and back-pressures ID/EX while an access is outstanding.
module mem_wb_stage_ctrl
  import mem_wb_stage_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int REG_ADDR_WIDTH  = 3,
  parameter int DMEM_ADDR_WIDTH = 8,
  parameter int TIMEOUT         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic                      w_reg_en_i,
  input  logic                      w_mem_en_i,
  input  logic [DATA_WIDTH-1:0]     r1_i,
  input  logic [DATA_WIDTH-1:0]     r2_i,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_1_i,
  output logic                      in_ready,
  mem_wb_stage_ctrl_if.master       dmem,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      err_timeout,
  output logic                      illegal_op,
  output logic [CNT_W-1:0]          n_loads,
  output logic [CNT_W-1:0]          n_stores
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            accept, mem_op, ack_ok, tmo_hit, load_done, store_done;
  logic            unused_r1_hi;

  assign unused_r1_hi = ^r1_i[DATA_WIDTH-1:DMEM_ADDR_WIDTH];

  assign in_ready = (state == IDLE);
  assign accept   = valid_i & in_ready;
  assign mem_op   = w_mem_en_i | w_reg_en_i;
  // ack only counts while a request is actually on the bus
  assign ack_ok   = dmem.dmem_req & dmem.dmem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tmo_hit    = 1'b0;
    load_done  = 1'b0;
    store_done = 1'b0;
    case (state)
      IDLE:     if (accept && mem_op) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (ack_ok) begin
          store_done = dmem.dmem_we;
          state_nxt  = dmem.dmem_we ? IDLE : WB;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      err_timeout     <= 1'b0;
      illegal_op      <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      illegal_op <= accept & w_mem_en_i & w_reg_en_i;
      rf_we      <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tmo_cnt <= '0;
          if (mem_op) begin
            // both enables set degrades to a plain store
            dmem.dmem_req  <= 1'b1;
            dmem.dmem_we   <= w_mem_en_i;
            dmem.dmem_addr <= r1_i[DMEM_ADDR_WIDTH-1:0];
            if (w_mem_en_i) dmem.dmem_wdata <= r2_i;
            else            rf_waddr        <= w_reg_1_i;
          end
        end
        MEM_WAIT: begin
          if (ack_ok) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) begin
              rf_we    <= 1'b1;
              rf_wdata <= dmem.dmem_rdata;
            end
          end else if (tmo_hit) begin
            dmem.dmem_req <= 1'b0;
            err_timeout   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mem_wb_stage_ctrl_sat_counter #(.WIDTH(CNT_W)) u_cnt_loads (
    .clk   (clk),
    .reset (reset),
    .inc   (load_done),
    .count (n_loads)
  );

  mem_wb_stage_ctrl_sat_counter #(.WIDTH(CNT_W)) u_cnt_stores (
    .clk   (clk),
    .reset (reset),
    .inc   (store_done),
    .count (n_stores)
  );
endmodule
